// File: rtl/ir_nec_receiver.sv
// NEC IR frame decoder for a demodulated, active-low receiver output.
// Level widths are measured in NEC units and checked against frame structure.
module ir_nec_receiver #(
  parameter int UNIT_CYCLES    = 28125,
  parameter bit CHECK_ADDR_INV = 1'b1,
  parameter bit CHECK_CMD_INV  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ir_in,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       valid,
  output logic       repeat_code,
  output logic       err
);

  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_STOP
  } state_t;

  state_t        state;
  logic          sync1, sync2, prev;
  logic [PW-1:0] pre;
  logic [4:0]    units;
  logic [4:0]    bit_cnt;
  logic [31:0]   shreg;

  logic       edge_det, fall, rise, wrap, timeout, inv_ok;
  logic [4:0] width;

  assign edge_det = sync2 ^ prev;
  assign fall     = edge_det & ~sync2;
  assign rise     = edge_det & sync2;
  assign wrap     = (pre == PRE_MAX);
  // The edge cycle itself may complete a unit, so fold a pending wrap in.
  assign width    = (wrap && units != 5'd31) ? units + 5'd1 : units;
  assign timeout  = (state != IDLE) && (units >= 5'd25);
  assign inv_ok   = (!CHECK_ADDR_INV || shreg[15:8]  == ~shreg[7:0]) &&
                    (!CHECK_CMD_INV  || shreg[31:24] == ~shreg[23:16]);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b1;
      pre         <= '0;
      units       <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      state       <= IDLE;
      addr        <= '0;
      cmd         <= '0;
      valid       <= 1'b0;
      repeat_code <= 1'b0;
      err         <= 1'b0;
    end else begin
      sync1 <= ir_in;
      sync2 <= sync1;
      prev  <= sync2;

      if (edge_det) begin
        pre   <= '0;
        units <= '0;
      end else if (wrap) begin
        pre <= '0;
        if (units != 5'd31) units <= units + 5'd1;
      end else begin
        pre <= pre + PW'(1);
      end

      valid       <= 1'b0;
      repeat_code <= 1'b0;
      err         <= 1'b0;

      if (timeout) begin
        err   <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (fall) state <= LEAD_MARK;
          LEAD_MARK:
            if (rise) state <= (width >= 5'd12 && width <= 5'd20) ? LEAD_SPACE : IDLE;
          LEAD_SPACE:
            if (fall) begin
              if (width >= 5'd6 && width <= 5'd10) begin
                state   <= BIT_MARK;
                bit_cnt <= '0;
              end else if (width >= 5'd3 && width <= 5'd5) begin
                state <= REP_STOP;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          BIT_MARK:
            if (rise) begin
              if (width <= 5'd1) state <= BIT_SPACE;
              else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          BIT_SPACE:
            if (fall) begin
              if (width <= 5'd4) begin
                shreg <= {(width >= 5'd2), shreg[31:1]};
                if (bit_cnt == 5'd31) state <= STOP_MARK;
                else begin
                  bit_cnt <= bit_cnt + 5'd1;
                  state   <= BIT_MARK;
                end
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          STOP_MARK:
            if (rise) begin
              state <= IDLE;
              if (width <= 5'd1 && inv_ok) begin
                addr  <= shreg[7:0];
                cmd   <= shreg[23:16];
                valid <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          REP_STOP:
            if (rise) begin
              state <= IDLE;
              if (width <= 5'd1) repeat_code <= 1'b1;
              else err <= 1'b1;
            end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
